// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - main-memory line transfer bus between the data cache and memory
// Purpose: groups the request/acknowledge handshake and the 128-bit line buses.
// Ports (signals):
//   mem_req_o    cache -> mem  request valid, held until mem_ack_i
//   mem_we_o     cache -> mem  1 = line write (writeback), 0 = line read (allocate)
//   mem_addr_o   cache -> mem  line-aligned byte address, [3:0] = 0
//   mem_wdata_o  cache -> mem  victim line, word 0 in [31:0]
//   mem_rdata_i  mem -> cache  fill line, word 0 in [31:0]
//   mem_ack_i    mem -> cache  one-cycle pulse completing the presented request
interface dcache_ctrl_if;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Purpose: MEM-stage data cache; serves hits in zero cycles, stalls the pipeline on a
// miss while writing back a dirty victim and filling the line from main memory.
// Ports:
//   Clock_i     rising-edge clock
//   Reset_i     synchronous active-high reset (clears valid/dirty, returns to IDLE)
//   MemRead_i   load request
//   MemWrite_i  store request (wins when both are set)
//   Addr_i      byte address: [3:2] word, [3+INDEX_BITS:4] index, upper bits tag
//   WData_i     store data
//   RData_o     load data, zero unless a read hit in IDLE
//   Stall_o     pipeline freeze while an access is not being served
//   mem         master side of the main-memory line bus
module dcache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WData_i,
    output logic [31:0] RData_o,
    output logic        Stall_o,
    dcache_ctrl_if.master mem
);
    localparam int TAG_W = 28 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;

    state_e              state_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [127:0]        data_q [LINES];

    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [127:0]        mem_wdata_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            word;
    logic [6:0]            word_lsb;
    logic                  access;
    logic                  is_store;
    logic                  hit;
    logic [127:0]          line;
    logic [31:0]           sel_word;
    logic                  unused_byte_bits;

    assign idx      = Addr_i[3+INDEX_BITS:4];
    assign tag      = Addr_i[31:4+INDEX_BITS];
    assign word     = Addr_i[3:2];
    assign word_lsb = {word, 5'b0};
    assign unused_byte_bits = ^Addr_i[1:0];

    assign access   = MemRead_i | MemWrite_i;
    assign is_store = MemWrite_i;
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign line     = data_q[idx];
    assign sel_word = line[word_lsb +: 32];

    // Combinational so a miss freezes the pipeline in the very cycle it appears.
    assign Stall_o  = access & ~((state_q == S_IDLE) & hit);
    assign RData_o  = ((state_q == S_IDLE) && hit && MemRead_i && !is_store) ? sel_word : 32'h0;

    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_we_o    = mem_we_q;
    assign mem.mem_addr_o  = mem_addr_q;
    assign mem.mem_wdata_o = mem_wdata_q;

    // Bus outputs are loaded on state entry; Addr_i and the victim line are stable for
    // the whole miss because the pipeline is frozen and the line is not touched until
    // the fill, so the registered copies always match what the state would present.
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (is_store) begin
                                data_q[idx][word_lsb +: 32] <= WData_i;
                                dirty_q[idx]                <= 1'b1;
                            end
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= S_WRITEBACK;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx, 4'b0};
                            mem_wdata_q <= line;
                        end else begin
                            state_q     <= S_ALLOCATE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= {Addr_i[31:4], 4'b0};
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem.mem_ack_i) begin
                        // Request stays high straight into the fill.
                        dirty_q[idx] <= 1'b0;
                        state_q      <= S_ALLOCATE;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= {Addr_i[31:4], 4'b0};
                        mem_wdata_q  <= '0;
                    end
                end
                S_ALLOCATE: begin
                    if (mem.mem_ack_i) begin
                        data_q[idx]  <= mem.mem_rdata_i;
                        tag_q[idx]   <= tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= S_IDLE;
                        mem_req_q    <= 1'b0;
                        mem_addr_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_i, wr_i;
    logic [31:0] addr, wdata, rdata;
    logic        stall;

    always #5 clk = ~clk;

    dcache_ctrl_if mif();

    dcache_ctrl #(.INDEX_BITS(5)) dut (
        .Clock_i   (clk),
        .Reset_i   (rst),
        .MemRead_i (rd_i),
        .MemWrite_i(wr_i),
        .Addr_i    (addr),
        .WData_i   (wdata),
        .RData_o   (rdata),
        .Stall_o   (stall),
        .mem       (mif)
    );

    int checks   = 0;
    int failures = 0;

    // Main memory model state
    int           ack_delay   = 0;
    int           wb_count    = 0;
    int           rd_count    = 0;
    int           req_cycles  = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_rd_addr = '0;
    logic [127:0] last_wb_data = '0;
    logic [127:0] backing [logic [31:0]];

    // Flat view of memory contents as the program sees it
    logic [31:0]  shadow [logic [31:0]];

    typedef struct {
        string        name;
        bit           st;
        logic [31:0]  a;
        logic [31:0]  wd;
        int           d;
        logic [31:0]  er;
        int           es;
        bit           ewb;
        logic [31:0]  ewa;
        logic [127:0] ewd;
        logic [31:0]  era;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word_init(input logic [31:0] wa);
        return wa ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] line_init(input logic [31:0] la);
        return {word_init(la + 12), word_init(la + 8), word_init(la + 4), word_init(la)};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (backing.exists(la)) return backing[la];
        return line_init(la);
    endfunction

    function automatic logic [31:0] sh_read(input logic [31:0] wa);
        if (shadow.exists(wa)) return shadow[wa];
        return word_init(wa);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay extra request cycles.
    initial begin
        int cnt;
        cnt = 0;
        mif.mem_ack_i   = 1'b0;
        mif.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            mif.mem_ack_i   = 1'b0;
            mif.mem_rdata_i = '0;
            if (rst) begin
                cnt = 0;
            end else if (mif.mem_req_o) begin
                req_cycles++;
                cnt++;
                if (cnt > ack_delay) begin
                    cnt = 0;
                    mif.mem_ack_i = 1'b1;
                    if (mif.mem_we_o) begin
                        backing[mif.mem_addr_o] = mif.mem_wdata_o;
                        wb_count++;
                        last_wb_addr = mif.mem_addr_o;
                        last_wb_data = mif.mem_wdata_o;
                    end else begin
                        mif.mem_rdata_i = mem_line(mif.mem_addr_o);
                        rd_count++;
                        last_rd_addr = mif.mem_addr_o;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic add_vec(input string nm, input bit st, input logic [31:0] a, input logic [31:0] wd,
                           input int d, input logic [31:0] er, input int es, input bit ewb,
                           input logic [31:0] ewa, input logic [127:0] ewd, input logic [31:0] era);
        vec_t v;
        v.name = nm; v.st = st; v.a = a; v.wd = wd; v.d = d; v.er = er; v.es = es;
        v.ewb = ewb; v.ewa = ewa; v.ewd = ewd; v.era = era;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge; returns just after the edge that retires the access.
    task automatic run_access(input string nm, input bit st, input logic [31:0] a, input logic [31:0] wd,
                              input int d, input logic [31:0] er, input int es, input bit ewb,
                              input logic [31:0] ewa, input logic [127:0] ewd, input logic [31:0] era);
        int wb0, rd0, rq0, sc, exp_req;
        bit leak;
        wb0 = wb_count; rd0 = rd_count; rq0 = req_cycles; sc = 0; leak = 0;
        ack_delay = d;
        rd_i = !st; wr_i = st; addr = a; wdata = wd;
        @(negedge clk);
        while (stall && sc < 100) begin
            sc++;
            if (rdata !== 32'h0) leak = 1'b1;
            @(negedge clk);
        end
        chk({nm, " stall_cycles"}, sc, es);
        chk({nm, " rdata"}, rdata, er);
        chk({nm, " rdata_zero_while_stalled"}, leak, 0);
        chk({nm, " req_low_on_serve"}, mif.mem_req_o, 0);
        chk({nm, " writebacks"}, wb_count - wb0, ewb ? 1 : 0);
        chk({nm, " fills"}, rd_count - rd0, (es != 0) ? 1 : 0);
        exp_req = (es == 0) ? 0 : (ewb ? 2 * (d + 1) : d + 1);
        chk({nm, " req_cycles"}, req_cycles - rq0, exp_req);
        if (ewb) begin
            chk({nm, " wb_addr"}, last_wb_addr, ewa);
            chk({nm, " wb_data"}, last_wb_data, ewd);
        end
        if (es != 0) chk({nm, " fill_addr"}, last_rd_addr, era);
        @(posedge clk);
        #1;
        rd_i = 1'b0; wr_i = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " stall"}, stall, 0);
        chk({nm, " rdata"}, rdata, 0);
        chk({nm, " mem_req"}, mif.mem_req_o, 0);
        chk({nm, " mem_we"}, mif.mem_we_o, 0);
        chk({nm, " mem_addr"}, mif.mem_addr_o, 0);
        chk({nm, " mem_wdata"}, mif.mem_wdata_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv[4];
        bit rdty[4];
        int rt[4];

        rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0; addr = '0; wdata = '0;
        backing[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // name, st, addr, wdata, delay, exp rdata, exp stalls, exp wb, wb addr, wb data, fill addr
        add_vec("ld100",    0, 32'h100, 0,            3, 32'd1,        5, 0, 0, 0, 32'h100);
        add_vec("ld10c",    0, 32'h10C, 0,            3, 32'd4,        0, 0, 0, 0, 0);
        add_vec("st104",    1, 32'h104, 32'hDEADBEEF, 3, 32'd0,        0, 0, 0, 0, 0);
        add_vec("ld104",    0, 32'h104, 0,            3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        add_vec("ld300",    0, 32'h300, 0,            3, 32'hA5A50300, 9, 1, 32'h100,
                {32'd4, 32'd3, 32'hDEADBEEF, 32'd1}, 32'h300);
        add_vec("st020",    1, 32'h020, 32'h55,       3, 32'd0,        5, 0, 0, 0, 32'h020);
        add_vec("ld020",    0, 32'h020, 0,            3, 32'h55,       0, 0, 0, 0, 0);
        add_vec("ld104_re", 0, 32'h104, 0,            3, 32'hDEADBEEF, 5, 0, 0, 0, 32'h100);
        add_vec("ld820",    0, 32'h820, 0,            1, 32'hA5A50820, 5, 1, 32'h020,
                {32'hA5A5002C, 32'hA5A50028, 32'hA5A50024, 32'h55}, 32'h820);

        foreach (vecs[i])
            run_access(vecs[i].name, vecs[i].st, vecs[i].a, vecs[i].wd, vecs[i].d, vecs[i].er,
                       vecs[i].es, vecs[i].ewb, vecs[i].ewa, vecs[i].ewd, vecs[i].era);

        // Reset while a fill is outstanding
        ack_delay = 10;
        rd_i = 1'b1; addr = 32'h540;
        repeat (3) @(negedge clk);
        chk("abort stall", stall, 1);
        chk("abort mem_req", mif.mem_req_o, 1);
        chk("abort mem_we", mif.mem_we_o, 0);
        chk("abort mem_addr", mif.mem_addr_o, 32'h540);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check_idle("after_abort");
        @(posedge clk);
        #1;
        run_access("reld540", 0, 32'h540, 0, 2, 32'hA5A50540, 4, 0, 0, 0, 32'h540);
        run_access("reld100", 0, 32'h100, 0, 2, 32'd1,        4, 0, 0, 0, 32'h100);

        // Randomised traffic in a fresh region, checked against a flat-memory model
        do_reset();
        for (int i = 0; i < 4; i++) begin rv[i] = 0; rdty[i] = 0; rt[i] = 0; end
        for (int n = 0; n < 300; n++) begin
            int d, tg, ix, w, es;
            bit st, hit, dv;
            logic [31:0] a, wd, va, er;
            logic [127:0] vd;
            d  = $urandom_range(0, 3);
            st = 1'($urandom_range(0, 1));
            tg = $urandom_range(0, 2);
            ix = $urandom_range(0, 3);
            w  = $urandom_range(0, 3);
            wd = $urandom;
            a  = 32'hA000_0000 | (tg << 9) | (ix << 4) | (w << 2);
            hit = rv[ix] && (rt[ix] == tg);
            dv  = !hit && rv[ix] && rdty[ix];
            va  = 32'hA000_0000 | (rt[ix] << 9) | (ix << 4);
            vd  = {sh_read(va + 12), sh_read(va + 8), sh_read(va + 4), sh_read(va)};
            es  = hit ? 0 : (dv ? 1 + 2 * (d + 1) : 1 + (d + 1));
            er  = st ? 32'h0 : sh_read(a);
            run_access($sformatf("rnd%0d", n), st, a, wd, d, er, es, dv, va, vd, {a[31:4], 4'b0});
            if (!hit) begin rv[ix] = 1; rt[ix] = tg; rdty[ix] = 0; end
            if (st) begin rdty[ix] = 1; shadow[a] = wd; end
        end

        @(negedge clk);
        check_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
